// File: rtl/command_manager.sv
// command_manager: decodes USART commands into register-bank writes/reads and packs responses; CMD_MANAGER_TIMEOUT_EN bounds the read wait
module command_manager #(
  parameter int MSG_LENGTH     = 48,
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRWIDTH      = 8,
  parameter int COMMAND_WIDTH  = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rsnt,
  input  logic                     packet_received,
  input  logic [COMMAND_WIDTH-1:0] command,
  input  logic [ADDRWIDTH-1:0]     reg_addr,
  input  logic [DATA_LENGTH-1:0]   rx_data,
  output logic                     send_data,
  output logic [MSG_LENGTH-1:0]    tx_data,
  input  logic                     data_sent,
  output logic                     rb_wr_en,
  output logic                     rb_rd_en,
  output logic [ADDRWIDTH-1:0]     rb_addr,
  output logic [DATA_LENGTH-1:0]   rb_wr_data,
  input  logic [DATA_LENGTH-1:0]   rb_rd_data,
  input  logic                     rb_rd_valid,
  output logic                     busy,
  output logic [7:0]               drop_count
);
  typedef enum logic [2:0] {IDLE, DECODE, WRITE, READ_WAIT, SEND, WAIT_SENT} state_t;
  localparam logic [COMMAND_WIDTH-1:0] OP_WRITE = COMMAND_WIDTH'(1);
  localparam logic [COMMAND_WIDTH-1:0] OP_READ  = COMMAND_WIDTH'(2);
  state_t state, next;
  logic [COMMAND_WIDTH-1:0] cmd_q;
  logic [ADDRWIDTH-1:0]     addr_q;
  logic [DATA_LENGTH-1:0]   data_q;
  logic [DATA_LENGTH-1:0]   resp_d;
  logic [2:0]               status_d;
  logic                     bad_hold;
  logic                     timed_out;
`ifdef CMD_MANAGER_TIMEOUT_EN
  logic [7:0] wait_cnt;
  always_ff @(posedge clk or posedge rsnt)
    if (rsnt) wait_cnt <= '0;
    else wait_cnt <= (state == READ_WAIT) ? wait_cnt + 8'd1 : '0;
  assign timed_out = (state == READ_WAIT) && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif
  assign busy       = state != IDLE;
  assign rb_wr_en   = state == WRITE;
  assign rb_rd_en   = (state == DECODE) && (cmd_q == OP_READ);
  assign rb_addr    = addr_q;
  assign rb_wr_data = data_q;
  // bad opcodes spend a second cycle in DECODE so they answer with the same latency as writes
  always_comb begin
    next     = state;
    status_d = 3'b000;
    resp_d   = '0;
    case (state)
      IDLE:      next = packet_received ? DECODE : IDLE;
      DECODE:
        if (cmd_q == OP_WRITE) next = WRITE;
        else if (cmd_q == OP_READ) next = READ_WAIT;
        else begin
          next     = bad_hold ? SEND : DECODE;
          status_d = 3'b001;
        end
      WRITE: begin
        next   = SEND;
        resp_d = data_q;
      end
      READ_WAIT:
        if (rb_rd_valid) begin
          next   = SEND;
          resp_d = rb_rd_data;
        end else if (timed_out) begin
          next     = SEND;
          status_d = 3'b010;
        end
      SEND:      next = WAIT_SENT;
      WAIT_SENT: next = data_sent ? IDLE : WAIT_SENT;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rsnt)
    if (rsnt) begin
      state      <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      bad_hold   <= 1'b0;
      send_data  <= 1'b0;
      tx_data    <= '0;
      drop_count <= '0;
    end else begin
      state    <= next;
      bad_hold <= (state == DECODE) && (next == DECODE);
      if (state == IDLE && packet_received) begin
        cmd_q  <= command;
        addr_q <= reg_addr;
        data_q <= rx_data;
      end
      if (state != IDLE && packet_received && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (next == SEND) begin
        tx_data   <= MSG_LENGTH'({status_d, cmd_q, addr_q, resp_d});
        send_data <= 1'b1;
      end else if (state == WAIT_SENT && data_sent) send_data <= 1'b0;
    end
endmodule

// File: tb/tb_command_manager.sv
// tb_command_manager: scoreboard bench; a negedge monitor checks each response against queued expectations
module tb_command_manager;
  logic        clk = 0, rsnt = 0, packet_received = 0, data_sent = 0, rb_rd_valid = 0;
  logic [4:0]  command = 0;
  logic [7:0]  reg_addr = 0;
  logic [31:0] rx_data = 0, rb_rd_data = 0;
  logic        send_data, rb_wr_en, rb_rd_en, busy;
  logic [47:0] tx_data;
  logic [7:0]  rb_addr, drop_count;
  logic [31:0] rb_wr_data;
  int n_cmp = 0, n_err = 0, cyc = 0, pulse_cyc = 0, wr_cnt = 0, rd_cnt = 0, overlap = 0;
  logic [7:0]  wr_addr_seen = 0;
  logic [31:0] wr_data_seen = 0;
  typedef struct {logic [47:0] tx; int lat;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic send_prev = 0;
  logic [47:0] held = 0;

  command_manager dut (
    .clk(clk), .rsnt(rsnt), .packet_received(packet_received), .command(command),
    .reg_addr(reg_addr), .rx_data(rx_data), .send_data(send_data), .tx_data(tx_data),
    .data_sent(data_sent), .rb_wr_en(rb_wr_en), .rb_rd_en(rb_rd_en), .rb_addr(rb_addr),
    .rb_wr_data(rb_wr_data), .rb_rd_data(rb_rd_data), .rb_rd_valid(rb_rd_valid),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsnt) send_prev = 0;
    else begin
      if (rb_wr_en) begin
        wr_cnt++;
        wr_addr_seen = rb_addr;
        wr_data_seen = rb_wr_data;
      end
      if (rb_rd_en) rd_cnt++;
      if (rb_wr_en && rb_rd_en) overlap++;
      if (send_data && !send_prev) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_resp: got tx_data %h, none expected", tx_data);
        end else begin
          e = sb.pop_front();
          check("resp_tx", tx_data, e.tx);
          check("resp_latency", cyc - pulse_cyc, e.lat);
        end
        held = tx_data;
      end else if (send_data && send_prev) check("tx_hold", tx_data, held);
      send_prev = send_data;
    end
  end

  task automatic expect_resp(input logic [47:0] tx, input int lat);
    exp_t x;
    x.tx = tx;
    x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic cmd(input logic [4:0] op, input logic [7:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 command = op; reg_addr = a; rx_data = d; packet_received = 1; pulse_cyc = cyc;
    @(posedge clk);
    #1 packet_received = 0;
  endtask

  task automatic wait_send();
    for (int i = 0; i < 600 && !send_data; i++) @(negedge clk);
    check("send_seen", send_data, 1);
  endtask

  task automatic finish_resp(input int hold);
    wait_send();
    repeat (hold) @(posedge clk);
    #1 data_sent = 1;
    @(posedge clk);
    #1 data_sent = 0;
    check("send_drop", send_data, 0);
    check("idle_after", busy, 0);
  endtask

  task automatic clear_counts();
    wr_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 rsnt = 1;
    #1;
    check("rst_send", send_data, 0);
    check("rst_busy", busy, 0);
    check("rst_tx", tx_data, 0);
    check("rst_drop", drop_count, 0);
    check("rst_addr", rb_addr, 0);
    @(posedge clk);
    #1 rsnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    #1 rsnt = 1;
    #2;
    check("rst_send", send_data, 0);
    check("rst_busy", busy, 0);
    check("rst_tx", tx_data, 0);
    check("rst_drop", drop_count, 0);
    check("rst_wr_en", rb_wr_en, 0);
    check("rst_rd_en", rb_rd_en, 0);
    repeat (2) @(posedge clk);
    #1 rsnt = 0;

    // write
    clear_counts();
    expect_resp(48'h0110_DEADBEEF, 3);
    cmd(5'h01, 8'h10, 32'hDEADBEEF);
    finish_resp(3);
    check("wr_count", wr_cnt, 1);
    check("wr_rd_count", rd_cnt, 0);
    check("wr_addr", wr_addr_seen, 8'h10);
    check("wr_data", wr_data_seen, 32'hDEADBEEF);

    // read, valid 4 cycles after rb_rd_en, stray data_sent in READ_WAIT ignored
    clear_counts();
    expect_resp(48'h0220_12345678, 6);
    cmd(5'h02, 8'h20, 32'h0);
    check("rd_en_seen", rb_rd_en, 1);
    check("rd_addr", rb_addr, 8'h20);
    @(posedge clk);
    #1 data_sent = 1;
    @(posedge clk);
    #1 data_sent = 0;
    repeat (2) @(posedge clk);
    #1 rb_rd_valid = 1; rb_rd_data = 32'h12345678;
    @(posedge clk);
    #1 rb_rd_valid = 0; rb_rd_data = 0;
    finish_resp(5);
    check("rd_count", rd_cnt, 1);
    check("rd_wr_count", wr_cnt, 0);

    // bad opcode
    clear_counts();
    expect_resp(48'h3F05_00000000, 3);
    cmd(5'h1F, 8'h05, 32'h11111111);
    finish_resp(2);
    check("bad_wr_count", wr_cnt, 0);
    check("bad_rd_count", rd_cnt, 0);

    // second pulse two cycles later is dropped, latched fields unchanged
    clear_counts();
    expect_resp(48'h0133_000000AA, 3);
    cmd(5'h01, 8'h33, 32'h000000AA);
    @(posedge clk);
    #1 command = 5'h02; reg_addr = 8'h99; rx_data = 32'h55555555; packet_received = 1;
    @(posedge clk);
    #1 packet_received = 0;
    finish_resp(1);
    check("drop_one", drop_count, 1);
    check("drop_rd_count", rd_cnt, 0);
    check("drop_wr_data", wr_data_seen, 32'h000000AA);

    // unanswered read while 300 packets arrive
    clear_counts();
`ifdef CMD_MANAGER_TIMEOUT_EN
    expect_resp(48'h4240_00000000, 257);
`endif
    cmd(5'h02, 8'h40, 32'h0);
    packet_received = 1;
    repeat (300) @(posedge clk);
    #1 packet_received = 0;
    check("drop_sat", drop_count, 8'hFF);
    check("stall_busy", busy, 1);
    check("stall_rd_count", rd_cnt, 1);
`ifndef CMD_MANAGER_TIMEOUT_EN
    check("stall_no_send", send_data, 0);
`endif
    async_reset();

    // reset during WAIT_SENT abandons the response; next write is normal
    expect_resp(48'h0144_00000055, 3);
    cmd(5'h01, 8'h44, 32'h00000055);
    wait_send();
    repeat (2) @(posedge clk);
    async_reset();
    clear_counts();
    expect_resp(48'h017F_CAFEF00D, 3);
    cmd(5'h01, 8'h7F, 32'hCAFEF00D);
    finish_resp(1);
    check("post_rst_wr_count", wr_cnt, 1);
    check("post_rst_wr_addr", wr_addr_seen, 8'h7F);

    repeat (2) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    check("strobe_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/command_manager.md
COMMAND_MANAGER -- requirements
Module: command_manager

Interface
REQ-001 Parameters SHALL be: MSG_LENGTH, default 48, response word width; DATA_LENGTH, default 32, register data width; ADDRWIDTH, default 8, register address width; COMMAND_WIDTH, default 5, opcode width; TIMEOUT_CYCLES, default 255, register read-wait limit.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rsnt  in  1  reset, asynchronous, active-high.
REQ-004 packet_received  in  1  one-cycle pulse: command/reg_addr/rx_data valid from USART manager.
REQ-005 command  in  COMMAND_WIDTH  received opcode.
REQ-006 reg_addr  in  ADDRWIDTH  received register address.
REQ-007 rx_data  in  DATA_LENGTH  received write data.
REQ-008 send_data  out  1  request to USART manager to transmit tx_data.
REQ-009 tx_data  out  MSG_LENGTH  response word.
REQ-010 data_sent  in  1  one-cycle pulse: response transmitted.
REQ-011 rb_wr_en / rb_rd_en  out  1 each  register-bank write / read strobes, one cycle.
REQ-012 rb_addr  out  ADDRWIDTH; rb_wr_data  out  DATA_LENGTH  register-bank address / write data.
REQ-013 rb_rd_data  in  DATA_LENGTH; rb_rd_valid  in  1  read data and its qualifier.
REQ-014 busy  out  1  high in any state except IDLE; drop_count  out  8  saturating count of commands dropped while busy.

Function
REQ-015 FSM states SHALL be IDLE, DECODE, WRITE, READ_WAIT, SEND, WAIT_SENT; encoding free.
REQ-016 IDLE: on packet_received, latch command, reg_addr, rx_data; go to DECODE next cycle.
REQ-017 DECODE: opcode 5'h01 -> WRITE; 5'h02 -> assert rb_rd_en one cycle, go READ_WAIT; any other opcode -> SEND with status BAD_CMD, data 0.
REQ-018 WRITE: rb_wr_en high exactly one cycle with latched address/data; go SEND with status OK, data = written value.
REQ-019 READ_WAIT: on rb_rd_valid, capture rb_rd_data, go SEND with status OK; rb_rd_valid in the same cycle rb_rd_en is asserted is ignored.
REQ-020 tx_data packing SHALL be [47:45] status (000 OK, 001 BAD_CMD, 010 TIMEOUT), [44:40] echoed opcode, [39:32] echoed address, [31:0] data; unused bits zero for non-default widths.
REQ-021 SEND: send_data high, tx_data registered and stable; go WAIT_SENT next cycle.
REQ-022 WAIT_SENT: send_data and tx_data held until data_sent pulse; send_data low the cycle after data_sent; return to IDLE.
REQ-023 data_sent outside WAIT_SENT SHALL be ignored.
REQ-024 packet_received in any state other than IDLE SHALL be dropped, drop_count +1, saturating at 255; latched fields unchanged.
REQ-025 Command latency: packet_received to send_data high = 3 cycles for write and bad opcode; read = 3 + cycles until rb_rd_valid.
REQ-026 rb_wr_en and rb_rd_en SHALL never be high together or for more than one cycle per command.

Reset
REQ-027 While rsnt high: state IDLE; send_data, rb_wr_en, rb_rd_en, busy low; tx_data, rb_addr, rb_wr_data, drop_count, latched fields zero; reset takes effect immediately, without clock.
REQ-028 Reset mid-transaction SHALL abandon the command with no response; first command after release handled normally.

Configuration
REQ-029 Macro CMD_MANAGER_TIMEOUT_EN defined: an 8-bit wait counter SHALL run in READ_WAIT; after TIMEOUT_CYCLES cycles without rb_rd_valid go SEND with status TIMEOUT, data 0; counter cleared on entering READ_WAIT.
REQ-030 Macro undefined: no counter; READ_WAIT waits indefinitely for rb_rd_valid; TIMEOUT status never produced.

Verification
REQ-031 Write: opcode 01, addr 0x10, data 0xDEADBEEF -> one rb_wr_en, rb_addr 0x10, tx_data 0x01_10_DEADBEEF, send_data 3 cycles after pulse.
REQ-032 Read: opcode 02, addr 0x20, rb_rd_valid 4 cycles after rb_rd_en with 0x12345678 -> tx_data 0x02_20_12345678, held until data_sent.
REQ-033 Bad opcode 0x1F, addr 0x05 -> no rb strobes, tx_data 0x3F_05_00000000 (BAD_CMD).
REQ-034 Two packet_received pulses 2 cycles apart -> second dropped, drop_count 1; 300 drops -> drop_count 255.
REQ-035 With CMD_MANAGER_TIMEOUT_EN, read never answered -> TIMEOUT response (tx_data[47:45]=010) after 255 cycles; without it, busy stays high.
REQ-036 rsnt asserted in WAIT_SENT -> send_data low immediately, busy low; next write completes normally.
